// File: rtl/tmr_fault_pkg.sv
// Shared types and constants for the TMR lane fault monitor.
// Lane codes match the bit positions of the voter's {err_c, err_b, err_a} flags.
package tmr_fault_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESYNC   = 2'd1,
    COOLDOWN = 2'd2,
    FATAL    = 2'd3
  } tmr_fault_state_e;

  localparam logic [1:0] LaneA    = 2'd0;
  localparam logic [1:0] LaneB    = 2'd1;
  localparam logic [1:0] LaneC    = 2'd2;
  localparam logic [1:0] LaneNone = 2'd3;

  // True when at least two of the three lanes flag an error in the same sample.
  function automatic logic multi_err(input logic [2:0] e);
    return (e[0] & e[1]) | (e[0] & e[2]) | (e[1] & e[2]);
  endfunction

endpackage

// File: rtl/tmr_lane_err_counter.sv
// Per-lane error bookkeeping: a saturating total-error counter and a
// consecutive-error streak counter that flags when the streak reaches Threshold.
module tmr_lane_err_counter #(
  parameter int CntWidth  = 8,
  parameter int Threshold = 4
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                sample,
  input  logic                err,
  input  logic                hold_consec,
  input  logic                freeze,
  input  logic                clear,
  output logic [CntWidth-1:0] total,
  output logic                consec_hit
);

  localparam logic [3:0]          HitLevel = 4'(Threshold - 1);
  localparam logic [CntWidth-1:0] TotalMax = '1;

  logic [CntWidth-1:0] total_reg;
  logic [3:0]          consec_reg;

  // Combinational so the FSM can move to RESYNC on the very sample that completes the streak.
  assign consec_hit = sample && err && !hold_consec && (consec_reg == HitLevel);
  assign total      = total_reg;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      total_reg  <= '0;
      consec_reg <= '0;
    end else begin
      if (sample && err && !freeze && (total_reg != TotalMax)) begin
        total_reg <= total_reg + 1'b1;
      end
      if (hold_consec || consec_hit) begin
        consec_reg <= '0;
      end else if (sample) begin
        if (!err) begin
          consec_reg <= '0;
        end else if (consec_reg != 4'hf) begin
          consec_reg <= consec_reg + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/tmr_fault_monitor.sv
// Tracks per-replica mismatch flags from the TMR voter, requests a resync when a
// lane errs Threshold times in a row, and latches a fatal flag on multi-lane errors.
module tmr_fault_monitor
  import tmr_fault_pkg::*;
#(
  parameter int CntWidth  = 8,
  parameter int Threshold = 4,
  parameter int Cooldown  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  input  logic [2:0]          err_i,
  input  logic                clear_i,
  input  logic                resync_ack_i,
  output logic                resync_req_o,
  output logic [1:0]          fault_lane_o,
  output logic                fatal_o,
  output logic [CntWidth-1:0] err_cnt_a_o,
  output logic [CntWidth-1:0] err_cnt_b_o,
  output logic [CntWidth-1:0] err_cnt_c_o
);

  localparam logic [7:0] CooldownLoad = 8'(Cooldown);

  tmr_fault_state_e    state_reg;
  logic [7:0]          timer_reg;
  logic                resync_req_reg;
  logic                fatal_reg;
  logic [1:0]          fault_lane_reg;

  logic [2:0]          consec_hit;
  logic [CntWidth-1:0] total [3];
  logic                hold_consec;
  logic                freeze;
  logic                multi;
  logic [1:0]          hit_lane;

  assign hold_consec = (state_reg != IDLE);
  assign freeze      = (state_reg == FATAL);
  assign multi       = valid_i && multi_err(err_i);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      tmr_lane_err_counter #(
        .CntWidth  (CntWidth),
        .Threshold (Threshold)
      ) u_cnt (
        .clk         (clk_i),
        .srst        (rst_i),
        .sample      (valid_i),
        .err         (err_i[gi]),
        .hold_consec (hold_consec),
        .freeze      (freeze),
        .clear       (clear_i),
        .total       (total[gi]),
        .consec_hit  (consec_hit[gi])
      );
    end
  endgenerate

  always_comb begin
    hit_lane = LaneNone;
    if (consec_hit[0]) begin
      hit_lane = LaneA;
    end else if (consec_hit[1]) begin
      hit_lane = LaneB;
    end else if (consec_hit[2]) begin
      hit_lane = LaneC;
    end
  end

  // clear_i outranks a simultaneous multi-error, which in turn outranks every other transition.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      resync_req_reg <= 1'b0;
      fatal_reg      <= 1'b0;
      fault_lane_reg <= LaneNone;
    end else if (multi && (state_reg != FATAL)) begin
      state_reg      <= FATAL;
      resync_req_reg <= 1'b0;
      fatal_reg      <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hit_lane != LaneNone) begin
            state_reg      <= RESYNC;
            resync_req_reg <= 1'b1;
            fault_lane_reg <= hit_lane;
          end
        end
        RESYNC: begin
          if (resync_ack_i) begin
            state_reg      <= COOLDOWN;
            resync_req_reg <= 1'b0;
            timer_reg      <= CooldownLoad;
          end
        end
        COOLDOWN: begin
          // Leaving on the last count keeps COOLDOWN exactly Cooldown cycles long.
          if (timer_reg <= 8'd1) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            fault_lane_reg <= LaneNone;
          end else begin
            timer_reg <= timer_reg - 8'd1;
          end
        end
        default: begin
          state_reg <= FATAL;
        end
      endcase
    end
  end

  assign resync_req_o = resync_req_reg;
  assign fault_lane_o = fault_lane_reg;
  assign fatal_o      = fatal_reg;
  assign err_cnt_a_o  = total[0];
  assign err_cnt_b_o  = total[1];
  assign err_cnt_c_o  = total[2];

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Directed bench for tmr_fault_monitor: a vector table for the main flow plus
// hand-written saturation (2-bit counters) and reset-during-resync sequences.
module tb_tmr_fault_monitor;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       valid_i = 1'b0;
  logic [2:0] err_i = 3'b000;
  logic       clear_i = 1'b0;
  logic       resync_ack_i = 1'b0;

  logic       resync_req_o, fatal_o;
  logic [1:0] fault_lane_o;
  logic [7:0] err_cnt_a_o, err_cnt_b_o, err_cnt_c_o;

  logic       req2, fatal2;
  logic [1:0] lane2;
  logic [1:0] cnt_a2, cnt_b2, cnt_c2;

  int total_checks  = 0;
  int passed_checks = 0;

  always #5 clk_i = ~clk_i;

  tmr_fault_monitor #(.CntWidth(8), .Threshold(4), .Cooldown(16)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .err_i        (err_i),
    .clear_i      (clear_i),
    .resync_ack_i (resync_ack_i),
    .resync_req_o (resync_req_o),
    .fault_lane_o (fault_lane_o),
    .fatal_o      (fatal_o),
    .err_cnt_a_o  (err_cnt_a_o),
    .err_cnt_b_o  (err_cnt_b_o),
    .err_cnt_c_o  (err_cnt_c_o)
  );

  tmr_fault_monitor #(.CntWidth(2), .Threshold(4), .Cooldown(16)) dut_sat (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .err_i        (err_i),
    .clear_i      (clear_i),
    .resync_ack_i (resync_ack_i),
    .resync_req_o (req2),
    .fault_lane_o (lane2),
    .fatal_o      (fatal2),
    .err_cnt_a_o  (cnt_a2),
    .err_cnt_b_o  (cnt_b2),
    .err_cnt_c_o  (cnt_c2)
  );

  typedef struct {
    logic       valid;
    logic [2:0] err;
    logic       clear;
    logic       ack;
    logic       exp_req;
    logic [1:0] exp_lane;
    logic       exp_fatal;
    int         exp_a;
    int         exp_b;
    int         exp_c;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [2:0] e, input logic c, input logic a,
                     input logic rq, input logic [1:0] ln, input logic ft,
                     input int ea, input int eb, input int ec);
    vec_t t;
    t.valid = v; t.err = e; t.clear = c; t.ack = a;
    t.exp_req = rq; t.exp_lane = ln; t.exp_fatal = ft;
    t.exp_a = ea; t.exp_b = eb; t.exp_c = ec;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total_checks++;
    if (act == exp) passed_checks++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Drive one cycle of inputs, then look at the registered outputs just after the edge.
  task automatic step(input logic v, input logic [2:0] e, input logic c, input logic a);
    valid_i = v; err_i = e; clear_i = c; resync_ack_i = a;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0; err_i = 3'b000; clear_i = 1'b0; resync_ack_i = 1'b0;
  endtask

  initial begin
    int n_err;
    int exp_sat;

    // Main flow, Threshold=4, Cooldown=16.
    add(0, 3'b000, 0, 0, 0, 3, 0, 0, 0, 0);
    add(1, 3'b001, 0, 0, 0, 3, 0, 1, 0, 0);
    add(1, 3'b001, 0, 0, 0, 3, 0, 2, 0, 0);
    add(1, 3'b000, 0, 0, 0, 3, 0, 2, 0, 0);
    add(1, 3'b001, 0, 0, 0, 3, 0, 3, 0, 0);
    add(1, 3'b001, 0, 0, 0, 3, 0, 4, 0, 0);
    add(0, 3'b001, 0, 0, 0, 3, 0, 4, 0, 0);
    add(1, 3'b010, 0, 0, 0, 3, 0, 4, 1, 0);
    add(1, 3'b010, 0, 0, 0, 3, 0, 4, 2, 0);
    add(1, 3'b010, 0, 0, 0, 3, 0, 4, 3, 0);
    add(1, 3'b010, 0, 0, 1, 1, 0, 4, 4, 0);
    add(1, 3'b100, 0, 0, 1, 1, 0, 4, 4, 1);
    add(1, 3'b000, 0, 1, 0, 1, 0, 4, 4, 1);
    for (int i = 0; i < 16; i++) begin
      add(1, 3'b100, 0, 0, 0, (i == 15) ? 2'd3 : 2'd1, 0, 4, 4, 2 + i);
    end
    for (int i = 0; i < 3; i++) begin
      add(1, 3'b100, 0, 0, 0, 3, 0, 4, 4, 18 + i);
    end
    add(1, 3'b100, 0, 0, 1, 2, 0, 4, 4, 21);
    add(1, 3'b011, 0, 0, 0, 2, 1, 5, 5, 21);
    add(1, 3'b111, 0, 0, 0, 2, 1, 5, 5, 21);
    add(1, 3'b000, 0, 1, 0, 2, 1, 5, 5, 21);
    add(1, 3'b011, 1, 0, 0, 3, 0, 0, 0, 0);
    add(1, 3'b001, 0, 0, 0, 3, 0, 1, 0, 0);
    add(1, 3'b000, 0, 1, 0, 3, 0, 1, 0, 0);

    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].valid, vecs[i].err, vecs[i].clear, vecs[i].ack);
      $display("vec %0d: v=%b err=%b clr=%b ack=%b -> req=%b lane=%0d fatal=%b cnt=%0d/%0d/%0d",
               i, vecs[i].valid, vecs[i].err, vecs[i].clear, vecs[i].ack,
               resync_req_o, fault_lane_o, fatal_o, err_cnt_a_o, err_cnt_b_o, err_cnt_c_o);
      check($sformatf("v%0d req", i),   int'(resync_req_o), int'(vecs[i].exp_req));
      check($sformatf("v%0d lane", i),  int'(fault_lane_o), int'(vecs[i].exp_lane));
      check($sformatf("v%0d fatal", i), int'(fatal_o),      int'(vecs[i].exp_fatal));
      check($sformatf("v%0d cnt_a", i), int'(err_cnt_a_o),  vecs[i].exp_a);
      check($sformatf("v%0d cnt_b", i), int'(err_cnt_b_o),  vecs[i].exp_b);
      check($sformatf("v%0d cnt_c", i), int'(err_cnt_c_o),  vecs[i].exp_c);
    end

    // Saturation: 10 lane-a errors, streak broken every third sample.
    step(0, 3'b000, 1, 0);
    check("sat clear cnt_a", int'(cnt_a2), 0);
    n_err = 0;
    for (int k = 0; k < 15; k++) begin
      if ((k % 3) == 2) begin
        step(1, 3'b000, 0, 0);
      end else begin
        step(1, 3'b001, 0, 0);
        n_err++;
      end
      exp_sat = (n_err > 3) ? 3 : n_err;
      $display("sat %0d: errors=%0d cnt2=%0d cnt8=%0d req2=%b", k, n_err, cnt_a2, err_cnt_a_o, req2);
      check($sformatf("sat%0d cnt_a2", k), int'(cnt_a2), exp_sat);
      check($sformatf("sat%0d cnt_a8", k), int'(err_cnt_a_o), n_err);
      check($sformatf("sat%0d req2", k), int'(req2), 0);
    end

    // Reset while waiting for an ack.
    for (int k = 0; k < 4; k++) step(1, 3'b010, 0, 0);
    $display("rst-pre: req=%b lane=%0d cnt_b=%0d", resync_req_o, fault_lane_o, err_cnt_b_o);
    check("rst pre req", int'(resync_req_o), 1);
    check("rst pre lane", int'(fault_lane_o), 1);
    rst_i = 1'b1;
    step(0, 3'b000, 0, 0);
    rst_i = 1'b0;
    $display("rst: req=%b lane=%0d fatal=%b cnt=%0d/%0d/%0d", resync_req_o, fault_lane_o, fatal_o,
             err_cnt_a_o, err_cnt_b_o, err_cnt_c_o);
    check("rst req", int'(resync_req_o), 0);
    check("rst lane", int'(fault_lane_o), 3);
    check("rst fatal", int'(fatal_o), 0);
    check("rst cnt_a", int'(err_cnt_a_o), 0);
    check("rst cnt_b", int'(err_cnt_b_o), 0);
    check("rst cnt_c", int'(err_cnt_c_o), 0);
    step(1, 3'b000, 0, 0);
    $display("post-rst: req=%b lane=%0d", resync_req_o, fault_lane_o);
    check("post rst req", int'(resync_req_o), 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
